// File: rtl/bit_source_buffer_pkg.sv
// ----------------------------------------------------------------------------
// bit_source_buffer_pkg
//   Shared definitions for the orbit word writer's upstream bit source:
//   default geometry of the byte store, the frame-start fill threshold used
//   by the writer, the prefetch FSM state encoding and a small helper that
//   counts the unconsumed bits left in the head register.
// ----------------------------------------------------------------------------
package bit_source_buffer_pkg;

    // Default byte-RAM address width: 2^11 = 2048 bytes = 16384 bits.
    localparam int ADDR_W_DEF    = 11;

    // Default width of the bit fill level; must hold 8*depth + 16.
    localparam int LEVEL_W_DEF   = 15;

    // Fill level at which the writer starts filling a frame.
    localparam int BIT_THRESHOLD = 10240;

    // Prefetch FSM: IDLE issues the RAM read, FETCH captures the read data.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    // Unconsumed bits remaining in the head register.
    function automatic logic [3:0] head_bits(input logic valid, input logic [2:0] idx);
        return valid ? (4'd8 - {1'b0, idx}) : 4'd0;
    endfunction

endpackage

// File: rtl/bit_source_buffer_byte_ram_sp.sv
// ----------------------------------------------------------------------------
// byte_ram_sp
//   Simple dual-port byte RAM: one write port, one read port with a
//   registered (1-cycle) read. Depth 2^ADDR_W x 8. Reading and writing the
//   same address in one cycle is never done by the owner, so no
//   read-during-write behaviour is defined.
//
// Ports
//   clk      in   system clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable; rdata_o updates on the next edge
//   raddr_i  in   read address
//   rdata_o  out  registered read data
// ----------------------------------------------------------------------------
module byte_ram_sp #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto a block RAM; contents are
    // only ever read after being written. Sequential state is assigned with
    // <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/bit_source_buffer.sv
// ----------------------------------------------------------------------------
// bit_source_buffer
//   Upstream feeder for the orbit word writer. Payload bytes are stored in a
//   byte RAM, staged through a prefetch register (next) into a head register,
//   and presented as a serial bit stream MSB first. Each rising edge of
//   bitRequest consumes the current head bit. bitLevel reports the number of
//   buffered, unconsumed bits (RAM + next + remaining head bits).
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   byteData    in   incoming payload byte
//   byteValid   in   one-cycle strobe accepting byteData
//   clear       in   synchronous flush of all stored data (flags are kept)
//   bitRequest  in   rising edge consumes the head bit
//   bitData     out  current head bit, 0 when nothing is buffered
//   bitLevel    out  buffered unconsumed bits (registered)
//   overflow    out  sticky: a byte was dropped because the RAM was full
//   underflow   out  sticky: a request edge found the head register empty
// ----------------------------------------------------------------------------
module bit_source_buffer
    import bit_source_buffer_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LEVEL_W = LEVEL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         byteData,
    input  logic               byteValid,
    input  logic               clear,
    input  logic               bitRequest,
    output logic               bitData,
    output logic [LEVEL_W-1:0] bitLevel,
    output logic               overflow,
    output logic               underflow
);

    localparam int              DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    ram_count_q, ram_count_d;
    logic [7:0]         next_byte_q, next_byte_d;
    logic               next_valid_q, next_valid_d;
    logic [7:0]         head_byte_q, head_byte_d;
    logic               head_valid_q, head_valid_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic               req_prev_q;
    logic [LEVEL_W-1:0] bit_level_q, bit_level_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               ram_full;
    logic               ram_we;
    logic               ram_re;
    logic               fetch_done;
    logic               req_edge;
    logic [7:0]         ram_rdata;

    byte_ram_sp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (byteData),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign ram_full = (ram_count_q == DEPTH_CNT);
    assign req_edge = bitRequest & ~req_prev_q;
    // A byte presented together with clear is discarded, not counted as dropped.
    assign ram_we   = byteValid & ~clear & ~ram_full;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        next_byte_d  = next_byte_q;
        next_valid_d = next_valid_q;
        head_byte_d  = head_byte_q;
        head_valid_d = head_valid_q;
        bit_idx_d    = bit_idx_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        ram_re       = 1'b0;
        fetch_done   = 1'b0;

        // Write path.
        if (ram_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (byteValid && ram_full && !clear) begin
            overflow_d = 1'b1;
        end

        // Prefetch: the RAM read is issued in IDLE and its data lands in FETCH.
        // next_valid_q stays 0 throughout FETCH, so the capture never collides
        // with a head load below.
        unique case (state_q)
            ST_IDLE: begin
                if (!next_valid_q && ram_count_q != '0) begin
                    ram_re  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fetch_done = 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A write and a fetch in the same cycle cancel out.
        ram_count_d = ram_count_q + {{ADDR_W{1'b0}}, ram_we} - {{ADDR_W{1'b0}}, fetch_done};

        // Consume path.
        if (req_edge) begin
            if (head_valid_q) begin
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) begin
                    head_valid_d = 1'b0;
                end
            end else begin
                underflow_d = 1'b1;
            end
        end

        // Head load, including the direct reload when the last bit was just
        // consumed on this edge.
        if (!head_valid_d && next_valid_q) begin
            head_byte_d  = next_byte_q;
            head_valid_d = 1'b1;
            bit_idx_d    = 3'd0;
            next_valid_d = 1'b0;
        end

        if (fetch_done) begin
            next_byte_d  = ram_rdata;
            next_valid_d = 1'b1;
        end

        // Flush: abandons any fetch in flight; sticky flags survive.
        if (clear) begin
            state_d      = ST_IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            ram_count_d  = '0;
            next_valid_d = 1'b0;
            head_valid_d = 1'b0;
            bit_idx_d    = 3'd0;
        end

        bit_level_d = LEVEL_W'({ram_count_d, 3'b000})
                    + LEVEL_W'({next_valid_d, 3'b000})
                    + LEVEL_W'(head_bits(head_valid_d, bit_idx_d));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            next_byte_q  <= '0;
            next_valid_q <= 1'b0;
            head_byte_q  <= '0;
            head_valid_q <= 1'b0;
            bit_idx_q    <= 3'd0;
            req_prev_q   <= 1'b0;
            bit_level_q  <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_count_q  <= ram_count_d;
            next_byte_q  <= next_byte_d;
            next_valid_q <= next_valid_d;
            head_byte_q  <= head_byte_d;
            head_valid_q <= head_valid_d;
            bit_idx_q    <= bit_idx_d;
            req_prev_q   <= bitRequest;
            bit_level_q  <= bit_level_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign bitData   = head_valid_q ? head_byte_q[3'd7 - bit_idx_q] : 1'b0;
    assign bitLevel  = bit_level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_bit_source_buffer.sv
// ----------------------------------------------------------------------------
// tb_bit_source_buffer
//   Directed and randomized stimulus for bit_source_buffer. The reference
//   model is a queue of bits: writes append 8 bits MSB first, each request
//   edge pops the front, the level is the queue length. Storage holds at
//   most depth bytes in RAM plus two staged bytes.
// ----------------------------------------------------------------------------
module tb_bit_source_buffer;
    import bit_source_buffer_pkg::*;

    localparam int ADDR_W    = 11;
    localparam int LEVEL_W   = 15;
    localparam int DEPTH     = 2**ADDR_W;
    localparam int CAP_BYTES = DEPTH + 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         byteData;
    logic               byteValid;
    logic               clear;
    logic               bitRequest;
    logic               bitData;
    logic [LEVEL_W-1:0] bitLevel;
    logic               overflow;
    logic               underflow;

    int n_checks = 0;
    int n_fail   = 0;

    bit model_q[$];
    bit m_ovf      = 1'b0;
    bit m_unf      = 1'b0;
    bit m_req_prev = 1'b0;

    bit_source_buffer #(
        .ADDR_W  (ADDR_W),
        .LEVEL_W (LEVEL_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .byteData   (byteData),
        .byteValid  (byteValid),
        .clear      (clear),
        .bitRequest (bitRequest),
        .bitData    (bitData),
        .bitLevel   (bitLevel),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic bit model_head();
        return (model_q.size() > 0) ? model_q[0] : 1'b0;
    endfunction

    // One clock with the given inputs; the model advances on the same edge and
    // level and flags are compared on the following falling edge.
    task automatic cycle(input logic bv, input logic [7:0] bd, input logic req, input logic clr);
        bit edge_seen;
        int held_bytes;
        byteValid  = bv;
        byteData   = bd;
        bitRequest = req;
        clear      = clr;
        @(posedge clk);
        edge_seen  = req && !m_req_prev;
        m_req_prev = req;
        held_bytes = (model_q.size() + 7) / 8;
        if (clr) begin
            model_q.delete();
        end else begin
            if (edge_seen) begin
                if (model_q.size() == 0) m_unf = 1'b1;
                else void'(model_q.pop_front());
            end
            if (bv) begin
                if (held_bytes >= CAP_BYTES) m_ovf = 1'b1;
                else for (int i = 7; i >= 0; i--) model_q.push_back(bd[i]);
            end
        end
        @(negedge clk);
        byteValid  = 1'b0;
        bitRequest = 1'b0;
        clear      = 1'b0;
        check("level", 32'(bitLevel), 32'(model_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Compare the head bit against the model, then consume it.
    task automatic request_bit(input int gap);
        check("bitdata", 32'(bitData), 32'(model_head()));
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(gap - 1);
    endtask

    initial begin
        logic [15:0] exp_bits;

        reset      = 1'b1;
        byteValid  = 1'b0;
        byteData   = 8'h00;
        clear      = 1'b0;
        bitRequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bitdata", 32'(bitData), 32'd0);
        check("rst_level", 32'(bitLevel), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        reset = 1'b0;

        // Two bytes read out MSB first, level counting down by one.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        idle(6);
        exp_bits = 16'b1010_0101_0011_1100;
        for (int i = 0; i < 16; i++) begin
            check("seq_bit", 32'(bitData), 32'(exp_bits[15-i]));
            check("seq_level", 32'(bitLevel), 32'(16 - i));
            request_bit(3);
        end
        check("seq_empty_bit", 32'(bitData), 32'd0);

        // 1281 bytes with no reads: the threshold is crossed on the last one.
        for (int i = 0; i < 1281; i++) begin
            cycle(1'b1, 8'(i * 37 + 11), 1'b0, 1'b0);
            if (i == 1279) begin
                check("thr_level_1280", 32'(bitLevel), 32'd10240);
                check("thr_below", 32'(bitLevel > BIT_THRESHOLD), 32'd0);
            end
        end
        check("thr_level_1281", 32'(bitLevel), 32'd10248);
        check("thr_above", 32'(bitLevel > BIT_THRESHOLD), 32'd1);
        check("thr_no_overflow", 32'(overflow), 32'd0);

        // Fill completely (RAM plus both staging registers), then one extra byte.
        for (int i = 1281; i < CAP_BYTES; i++) cycle(1'b1, 8'(i * 37 + 11), 1'b0, 1'b0);
        check("full_level", 32'(bitLevel), 32'(8 * DEPTH + 16));
        check("full_no_overflow", 32'(overflow), 32'd0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_level", 32'(bitLevel), 32'(8 * DEPTH + 16));
        idle(2);
        // Drain everything; the dropped byte must not appear.
        for (int i = 0; i < 8 * CAP_BYTES; i++) request_bit(2);
        idle(2);
        check("drain_level", 32'(bitLevel), 32'd0);
        check("drain_bitdata", 32'(bitData), 32'd0);
        check("drain_no_underflow", 32'(underflow), 32'd0);

        // Request edges on an empty buffer.
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
        check("unf_flag", 32'(underflow), 32'd1);
        check("unf_bitdata", 32'(bitData), 32'd0);
        check("unf_level", 32'(bitLevel), 32'd0);
        cycle(1'b1, 8'h80, 1'b0, 1'b0);
        idle(6);
        check("unf_first_bit", 32'(bitData), 32'd1);
        request_bit(3);
        check("unf_second_bit", 32'(bitData), 32'd0);
        for (int i = 1; i < 8; i++) request_bit(3);

        // Clear with 100 bytes buffered and a byte arriving in the same cycle.
        for (int i = 0; i < 100; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("pre_clear_level", 32'(bitLevel), 32'd800);
        cycle(1'b1, 8'hC3, 1'b0, 1'b1);
        check("clear_level", 32'(bitLevel), 32'd0);
        check("clear_bitdata", 32'(bitData), 32'd0);
        check("clear_overflow", 32'(overflow), 32'd1);
        check("clear_underflow", 32'(underflow), 32'd1);
        cycle(1'b1, 8'h96, 1'b0, 1'b0);
        idle(6);
        check("post_clear_first", 32'(bitData), 32'd1);
        for (int i = 0; i < 8; i++) request_bit(3);
        check("post_clear_empty", 32'(bitLevel), 32'd0);

        // Concurrent random stream: a byte every 8 cycles, a request every 3.
        for (int t = 0; t < 16 + 3 * 5000; t++) begin
            logic bv;
            logic rq;
            bv = (t % 8 == 0);
            rq = (t >= 16) && ((t - 16) % 3 == 0);
            if (rq) check("stream_bit", 32'(bitData), 32'(model_head()));
            cycle(bv, 8'($urandom), rq, 1'b0);
        end
        check("stream_overflow", 32'(overflow), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
